// File: rtl/crypt_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crypt_seq_pkg
//  Description : Shared types and constants for the modular-exponentiation
//                job sequencer (state encoding, result record, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package crypt_seq_pkg;

    // Width of messages, keys and results exchanged with the crypto core
    localparam int DATA_W   = 16;
    localparam int RESULT_W = DATA_W + 1;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_DONE  = 3'd2,
        GUARD_WAIT = 3'd3,
        RECOVER    = 3'd4
    } state_t;

    // One buffered result: err set means the job was abandoned by the watchdog
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } result_t;

    // Watchdog counter width able to hold TIMEOUT-1
    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crypt_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : crypt_out_fifo
//  Description : Small result FIFO (DEPTH x 17 bits) with registered pointers,
//                head-entry output and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module crypt_out_fifo
    import crypt_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  result_t                i_push_data,
    input  logic                   i_pop,
    output result_t                o_head,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_aw = $clog2(DEPTH);

    result_t         r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_aw + 1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when the head is leaving in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage is cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/crypt_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : crypt_job_sequencer
//  Description : Job front-end for the modular-exponentiation core. Takes
//                messages over valid/ready, runs one core job at a time,
//                detects completion on the rising edge of core_done, buffers
//                results and recovers a hung core with watchdog + core reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module crypt_job_sequencer
    import crypt_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096,
    parameter int GUARD   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_exp,
    input  logic [DATA_W-1:0] cfg_mod,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              core_start,
    output logic              core_rst,
    output logic [DATA_W-1:0] core_exp,
    output logic [DATA_W-1:0] core_mod,
    output logic [DATA_W-1:0] core_msg,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    localparam int c_wd_w  = wd_width(TIMEOUT);
    localparam int c_gd_w  = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    state_t             r_state;
    logic [c_wd_w-1:0]  r_wd;
    logic [c_gd_w-1:0]  r_guard;
    logic               r_rcnt;
    logic               r_done_q;
    logic               r_en;

    logic               w_idle;
    logic               w_cfg_take;
    logic               w_accept;
    logic               w_edge;
    logic               w_timeout;
    logic               w_push;
    result_t            w_push_data;
    result_t            w_head;
    logic               w_empty;
    logic               w_full;
    logic [c_cnt_w-1:0] w_count;

    assign w_idle = (r_state == IDLE);

    // Handshakes stay low until the first clock after reset release, so every
    // output reads 0 while rst_n is low.
    assign cfg_ready  = r_en & w_idle;
    assign in_ready   = r_en & w_idle & ~cfg_valid & (w_count < c_cnt_w'(DEPTH));
    assign w_cfg_take = cfg_valid & cfg_ready;
    assign w_accept   = in_valid & in_ready;
    assign busy       = ~w_idle;

    // The core holds cal_done from the previous job, so only a fresh rise
    // marks completion; an edge beats a simultaneous timeout.
    assign w_edge    = core_done & ~r_done_q;
    assign w_timeout = (r_wd == c_wd_w'(TIMEOUT - 1));
    assign w_push    = (r_state == WAIT_DONE) & (w_edge | w_timeout);
    assign w_push_data.err  = ~w_edge;
    assign w_push_data.data = w_edge ? core_val : '0;

    assign out_valid = ~w_empty;
    assign out_data  = w_head.data;
    assign out_err   = w_head.err;

    crypt_out_fifo #(
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (out_ready),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    // Handshake enable rises one clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    // Job sequencing state machine with registered core-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wd       <= '0;
            r_guard    <= '0;
            r_rcnt     <= 1'b0;
            r_done_q   <= 1'b0;
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            core_exp   <= '0;
            core_mod   <= '0;
            core_msg   <= '0;
        end else begin
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cfg_take) begin
                        core_exp <= cfg_exp;
                        core_mod <= cfg_mod;
                    end else if (w_accept) begin
                        core_msg   <= in_data;
                        core_start <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    r_done_q <= core_done;
                    if (w_edge) begin
                        r_guard <= '0;
                        r_state <= GUARD_WAIT;
                    end else if (w_timeout) begin
                        core_rst <= 1'b1;
                        r_rcnt   <= 1'b0;
                        r_state  <= RECOVER;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                GUARD_WAIT: begin
                    if (r_guard == c_gd_w'(GUARD - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_guard <= r_guard + 1'b1;
                    end
                end
                RECOVER: begin
                    // core_rst was raised on entry; hold it for a second cycle
                    if (!r_rcnt) begin
                        core_rst <= 1'b1;
                        r_rcnt   <= 1'b1;
                    end else begin
                        r_rcnt   <= 1'b0;
                        r_done_q <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crypt_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crypt_job_sequencer
//  Description : Self-checking bench for crypt_job_sequencer with a
//                behavioural modexp core and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crypt_job_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int GUARD   = 3;
    localparam int LAT     = 5;
    localparam int BOUND   = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_exp, cfg_mod;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        core_start, core_rst;
    logic [15:0] core_exp, core_mod, core_msg;
    logic        core_done;
    logic [15:0] core_val;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        busy;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    logic [16:0] sb[$];
    int          q_start[$];
    int          q_rise[$];
    int          t_acc, t_ov, t_rst_rise, last_rst_run, ir_busy;
    bit          hang = 1'b0;

    crypt_job_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .GUARD   (GUARD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_exp    (cfg_exp),
        .cfg_mod    (cfg_mod),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .core_start (core_start),
        .core_rst   (core_rst),
        .core_exp   (core_exp),
        .core_mod   (core_mod),
        .core_msg   (core_msg),
        .core_done  (core_done),
        .core_val   (core_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: result LAT cycles after start, done held until next start
    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                           input logic [15:0] m);
        longint r = 1;
        longint x;
        if (m == 0) return 16'd0;
        x = longint'(b) % longint'(m);
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % longint'(m);
            x = (x * x) % longint'(m);
        end
        return r[15:0];
    endfunction

    logic [15:0] m_b, m_e, m_m;
    int          m_cnt = 0;
    initial begin core_done = 1'b0; core_val = 16'd0; end

    always @(posedge clk) begin
        if (core_rst) begin
            core_done <= 1'b0;
            core_val  <= 16'd0;
            m_cnt     <= 0;
        end else if (core_start) begin
            m_b       <= core_msg;
            m_e       <= core_exp;
            m_m       <= core_mod;
            m_cnt     <= LAT;
            core_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !hang) begin
                core_done <= 1'b1;
                core_val  <= modexp(m_b, m_e, m_m);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: scoreboard pops plus event timestamps, sampled on negedge
    initial begin
        bit prev_done = 1'b0, prev_ov = 1'b0, prev_rst = 1'b0;
        int rst_run = 0;
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL scoreboard: unexpected result err=%0d data=%0d", out_err, out_data);
                    end else begin
                        e = sb.pop_front();
                        if ({out_err, out_data} == e) n_pass++;
                        else $display("FAIL scoreboard: got err=%0d data=%0d expected err=%0d data=%0d",
                                      out_err, out_data, e[16], e[15:0]);
                    end
                end
                if (core_start) q_start.push_back(cyc);
                if (core_done && !prev_done) q_rise.push_back(cyc);
                if (out_valid && !prev_ov) t_ov = cyc;
                if (busy && in_ready) ir_busy++;
                if (core_rst) begin
                    if (!prev_rst) t_rst_rise = cyc;
                    rst_run++;
                end else if (prev_rst) begin
                    last_rst_run = rst_run;
                    rst_run = 0;
                end
            end
            prev_done = core_done;
            prev_ov   = out_valid;
            prev_rst  = core_rst;
        end
    end

    task automatic do_cfg(input logic [15:0] e, input logic [15:0] m);
        int n = 0;
        cfg_valid = 1'b1; cfg_exp = e; cfg_mod = m;
        do begin @(negedge clk); n++; end while (!cfg_ready && n < BOUND);
        check("cfg_handshake", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Present a message and wait for acceptance; expected result is queued then
    task automatic push(input logic [15:0] d, input logic err, input logic [15:0] exp_d);
        int n = 0;
        in_valid = 1'b1; in_data = d;
        do begin @(negedge clk); n++; end while (!in_ready && n < BOUND);
        if (in_ready) begin
            t_acc = cyc;
            sb.push_back({err, exp_d});
        end else begin
            check("accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit drain);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((busy || (drain && out_valid)) && n < BOUND);
        check("idle_timeout", (busy || (drain && out_valid)) ? 1 : 0, 0);
        @(posedge clk); #1;
    endtask

    function automatic int outs_or();
        return int'(|{cfg_ready, in_ready, core_start, core_rst, core_exp, core_mod,
                      core_msg, out_valid, out_data, out_err, busy});
    endfunction

    initial begin
        int cnt;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_exp = '0; cfg_mod = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // 1. Reset state and release
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", outs_or(), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // 2. 9^3 mod 33 = 3: one start, latencies, in_ready low while busy
        @(posedge clk); #1;
        do_cfg(16'd3, 16'd33);
        q_start.delete(); q_rise.delete(); ir_busy = 0;
        push(16'd9, 1'b0, 16'd3);
        wait_idle(1'b1);
        check("single_start_pulse", q_start.size(), 1);
        check("accept_to_start", q_start[0] - t_acc, 1);
        check("done_to_out_valid", t_ov - q_rise[0], 1);
        check("in_ready_low_while_busy", ir_busy, 0);
        check("in_ready_back_high", in_ready, 1);

        // 3. 3^7 mod 33 = 9 twice back to back; held done must not re-trigger
        do_cfg(16'd7, 16'd33);
        q_start.delete(); q_rise.delete();
        push(16'd3, 1'b0, 16'd9);
        push(16'd3, 1'b0, 16'd9);
        wait_idle(1'b1);
        check("two_starts", q_start.size(), 2);
        check("guard_spacing", q_start[1] - q_rise[0], GUARD + 2);

        // 4. Fill FIFO with consumer stalled; fifth job blocked, in-order drain
        //    (m^3 mod 33: 9->3, 2->8, 4->31, 5->26, 7->13)
        do_cfg(16'd3, 16'd33);
        out_ready = 1'b0;
        push(16'd9, 1'b0, 16'd3);
        push(16'd2, 1'b0, 16'd8);
        push(16'd4, 1'b0, 16'd31);
        push(16'd5, 1'b0, 16'd26);
        wait_idle(1'b0);
        in_valid = 1'b1; in_data = 16'd7; cnt = 0;
        repeat (10) begin @(negedge clk); if (in_ready) cnt++; end
        check("in_ready_low_when_full", cnt, 0);
        check("results_queued", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(16'd7, 1'b0, 16'd13);
        wait_idle(1'b1);

        // 5. Hung core: watchdog, 2-cycle core_rst, error result, then recovery
        hang = 1'b1;
        q_start.delete(); last_rst_run = 0;
        push(16'd5, 1'b1, 16'd0);
        wait_idle(1'b1);
        check("core_rst_cycles", last_rst_run, 2);
        check("timeout_latency", t_rst_rise - q_start[0], TIMEOUT + 1);
        hang = 1'b0;
        push(16'd2, 1'b0, 16'd8);
        wait_idle(1'b1);

        // 6. Async reset mid-job with one queued entry: flushed, no stale push
        out_ready = 1'b0;
        push(16'd4, 1'b0, 16'd31);
        wait_idle(1'b0);
        push(16'd5, 1'b0, 16'd26);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs_zero", outs_or(), 0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1; cnt = 0;
        repeat (20) begin @(negedge clk); if (out_valid || busy) cnt++; end
        check("no_stale_push", cnt, 0);
        do_cfg(16'd3, 16'd33);
        push(16'd7, 1'b0, 16'd13);
        wait_idle(1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
